// File: rtl/paddle_ctrl.sv
// Pong paddle position from debounced up/down levels: immediate step on press, per-frame auto-repeat after a hold delay.
// Latency: a request sampled at a clock edge updates paddle_y at that same edge; flags decode from registered state.
// Backpressure: none, inputs are levels and ticks consumed every cycle. Optional PADDLE_ACCEL_EN doubles the repeat step.
module paddle_ctrl #(
    parameter int Y_W          = 10,
    parameter int Y_MAX        = 480,
    parameter int PADDLE_H     = 64,
    parameter int Y_INIT       = 208,
    parameter int STEP         = 4,
    parameter int HOLD_FRAMES  = 8,
    parameter int ACCEL_FRAMES = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           up_clean,
    input  logic           down_clean,
    input  logic           frame_tick,
    output logic [Y_W-1:0] paddle_y,
    output logic           at_top,
    output logic           at_bottom,
    output logic           moving
);

    localparam int HC_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
    localparam logic [Y_W:0]    LIM_X   = (Y_W+1)'(Y_MAX - PADDLE_H);
    localparam logic [Y_W:0]    STEP_X  = (Y_W+1)'(STEP);
    localparam logic [HC_W-1:0] HC_LAST = HC_W'(HOLD_FRAMES - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HOLD_UP = 3'd1,
        HOLD_DN = 3'd2,
        RPT_UP  = 3'd3,
        RPT_DN  = 3'd4
    } state_t;

    state_t          state, state_nxt;
    logic [HC_W-1:0] hold_cnt, hold_nxt;
    logic            dir_up, dir_dn;
    logic            do_up, do_dn;
    logic [Y_W:0]    y_x, step_x, y_up, y_dn;

    assign dir_up = up_clean & ~down_clean;
    assign dir_dn = down_clean & ~up_clean;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        do_up     = 1'b0;
        do_dn     = 1'b0;
        case (state)
            IDLE: begin
                if (dir_up) begin
                    state_nxt = HOLD_UP;
                    do_up     = 1'b1;
                    hold_nxt  = '0;
                end else if (dir_dn) begin
                    state_nxt = HOLD_DN;
                    do_dn     = 1'b1;
                    hold_nxt  = '0;
                end
            end
            HOLD_UP: begin
                if (dir_up) begin
                    if (frame_tick) begin
                        if (hold_cnt == HC_LAST) begin
                            state_nxt = RPT_UP;
                            hold_nxt  = '0;
                        end else begin
                            hold_nxt = hold_cnt + 1'b1;
                        end
                    end
                end else if (dir_dn) begin
                    state_nxt = HOLD_DN;
                    do_dn     = 1'b1;
                    hold_nxt  = '0;
                end else begin
                    state_nxt = IDLE;
                    hold_nxt  = '0;
                end
            end
            HOLD_DN: begin
                if (dir_dn) begin
                    if (frame_tick) begin
                        if (hold_cnt == HC_LAST) begin
                            state_nxt = RPT_DN;
                            hold_nxt  = '0;
                        end else begin
                            hold_nxt = hold_cnt + 1'b1;
                        end
                    end
                end else if (dir_up) begin
                    state_nxt = HOLD_UP;
                    do_up     = 1'b1;
                    hold_nxt  = '0;
                end else begin
                    state_nxt = IDLE;
                    hold_nxt  = '0;
                end
            end
            RPT_UP: begin
                if (dir_up) begin
                    do_up = frame_tick;
                end else if (dir_dn) begin
                    state_nxt = HOLD_DN;
                    do_dn     = 1'b1;
                    hold_nxt  = '0;
                end else begin
                    state_nxt = IDLE;
                    hold_nxt  = '0;
                end
            end
            RPT_DN: begin
                if (dir_dn) begin
                    do_dn = frame_tick;
                end else if (dir_up) begin
                    state_nxt = HOLD_UP;
                    do_up     = 1'b1;
                    hold_nxt  = '0;
                end else begin
                    state_nxt = IDLE;
                    hold_nxt  = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                hold_nxt  = '0;
            end
        endcase
    end

`ifdef PADDLE_ACCEL_EN
    localparam int RC_W = $clog2(ACCEL_FRAMES + 1);
    localparam logic [RC_W-1:0] RC_MAX  = RC_W'(ACCEL_FRAMES);
    localparam logic [Y_W:0]    STEP2_X = (Y_W+1)'(2 * STEP);

    logic [RC_W-1:0] rpt_cnt, rpt_nxt;
    logic            rpt_step, in_rpt_nxt;

    assign rpt_step   = ((state == RPT_UP) & do_up) | ((state == RPT_DN) & do_dn);
    assign in_rpt_nxt = (state_nxt == RPT_UP) | (state_nxt == RPT_DN);

    // Saturates at ACCEL_FRAMES: every repeat step after that many uses the doubled size.
    always_comb begin
        rpt_nxt = rpt_cnt;
        if (!in_rpt_nxt) begin
            rpt_nxt = '0;
        end else if (rpt_step && (rpt_cnt != RC_MAX)) begin
            rpt_nxt = rpt_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rpt_cnt <= '0;
        end else begin
            rpt_cnt <= rpt_nxt;
        end
    end

    assign step_x = (rpt_cnt == RC_MAX) ? STEP2_X : STEP_X;
`else
    assign step_x = STEP_X;
`endif

    // One extra bit of headroom keeps both directions free of wrap before clamping.
    assign y_x = {1'b0, paddle_y};

    always_comb begin
        y_up = (y_x < step_x) ? '0 : (y_x - step_x);
        y_dn = y_x + step_x;
        if (y_dn > LIM_X) begin
            y_dn = LIM_X;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            paddle_y <= Y_W'(Y_INIT);
        end else if (do_up) begin
            paddle_y <= y_up[Y_W-1:0];
        end else if (do_dn) begin
            paddle_y <= y_dn[Y_W-1:0];
        end
    end

    assign at_top    = (paddle_y == '0);
    assign at_bottom = (y_x == LIM_X);
    assign moving    = (state == RPT_UP) | (state == RPT_DN);

endmodule

// File: tb/tb_paddle_ctrl.sv
// Bench for paddle_ctrl: constant-expectation vector table, directed corner sequences, then random levels vs a press-age model.
// Three instances share inputs and differ only in Y_INIT so both saturation limits are reachable.
module tb_paddle_ctrl;

    localparam int Y_W          = 10;
    localparam int Y_MAX        = 480;
    localparam int PADDLE_H     = 64;
    localparam int STEP         = 4;
    localparam int HOLD_FRAMES  = 8;
    localparam int ACCEL_FRAMES = 16;
    localparam int YLIM         = Y_MAX - PADDLE_H;
    localparam int INIT0 = 208;
    localparam int INIT1 = 6;
    localparam int INIT2 = 414;

    logic clk = 1'b0;
    logic rst, up_clean, down_clean, frame_tick;
    logic [Y_W-1:0] py [3];
    logic at_t [3];
    logic at_b [3];
    logic mov  [3];

    int n_checks = 0;
    int n_err    = 0;

    int m_y [3];
    int m_prev;
    int m_ticks;

    always #5 clk = ~clk;

    paddle_ctrl #(.Y_W(Y_W), .Y_MAX(Y_MAX), .PADDLE_H(PADDLE_H), .Y_INIT(INIT0), .STEP(STEP),
                  .HOLD_FRAMES(HOLD_FRAMES), .ACCEL_FRAMES(ACCEL_FRAMES)) u_dut (
        .clk(clk), .rst(rst), .up_clean(up_clean), .down_clean(down_clean), .frame_tick(frame_tick),
        .paddle_y(py[0]), .at_top(at_t[0]), .at_bottom(at_b[0]), .moving(mov[0]));

    paddle_ctrl #(.Y_W(Y_W), .Y_MAX(Y_MAX), .PADDLE_H(PADDLE_H), .Y_INIT(INIT1), .STEP(STEP),
                  .HOLD_FRAMES(HOLD_FRAMES), .ACCEL_FRAMES(ACCEL_FRAMES)) u_dut_lo (
        .clk(clk), .rst(rst), .up_clean(up_clean), .down_clean(down_clean), .frame_tick(frame_tick),
        .paddle_y(py[1]), .at_top(at_t[1]), .at_bottom(at_b[1]), .moving(mov[1]));

    paddle_ctrl #(.Y_W(Y_W), .Y_MAX(Y_MAX), .PADDLE_H(PADDLE_H), .Y_INIT(INIT2), .STEP(STEP),
                  .HOLD_FRAMES(HOLD_FRAMES), .ACCEL_FRAMES(ACCEL_FRAMES)) u_dut_hi (
        .clk(clk), .rst(rst), .up_clean(up_clean), .down_clean(down_clean), .frame_tick(frame_tick),
        .paddle_y(py[2]), .at_top(at_t[2]), .at_bottom(at_b[2]), .moving(mov[2]));

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: a press is a change of requested direction; a held press ages by frame ticks,
    // and every tick past HOLD_FRAMES of age is a repeat step.
    function automatic void model_reset();
        m_y[0]  = INIT0;
        m_y[1]  = INIT1;
        m_y[2]  = INIT2;
        m_prev  = 0;
        m_ticks = 0;
    endfunction

    function automatic void model_step(input logic u, input logic d, input logic t);
        int dir;
        int s;
        bit stp;
        dir = (u && !d) ? -1 : ((d && !u) ? 1 : 0);
        stp = 1'b0;
        if (dir == 0) begin
            m_ticks = 0;
        end else if (dir != m_prev) begin
            m_ticks = 0;
            stp = 1'b1;
        end else if (t) begin
            m_ticks++;
            if (m_ticks > HOLD_FRAMES) stp = 1'b1;
        end
        s = STEP;
`ifdef PADDLE_ACCEL_EN
        if (m_ticks - HOLD_FRAMES > ACCEL_FRAMES) s = 2 * STEP;
`endif
        if (stp) begin
            for (int i = 0; i < 3; i++) begin
                m_y[i] = m_y[i] + dir * s;
                if (m_y[i] < 0) m_y[i] = 0;
                if (m_y[i] > YLIM) m_y[i] = YLIM;
            end
        end
        m_prev = dir;
    endfunction

    task automatic cycle(input logic u, input logic d, input logic t);
        up_clean   = u;
        down_clean = d;
        frame_tick = t;
        @(posedge clk);
        model_step(u, d, t);
        #1;
        frame_tick = 1'b0;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        up_clean   = 1'b0;
        down_clean = 1'b0;
        frame_tick = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic check_model();
        int mv;
        mv = (m_prev != 0 && m_ticks >= HOLD_FRAMES) ? 1 : 0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rand y[%0d]", i), int'(py[i]), m_y[i]);
            check($sformatf("rand at_top[%0d]", i), int'(at_t[i]), (m_y[i] == 0) ? 1 : 0);
            check($sformatf("rand at_bottom[%0d]", i), int'(at_b[i]), (m_y[i] == YLIM) ? 1 : 0);
            check($sformatf("rand moving[%0d]", i), int'(mov[i]), mv);
        end
    endtask

    typedef struct {
        logic u;
        logic d;
        logic t;
        int   y;
        logic mv;
    } vec_t;

    vec_t tbl [12];

    initial begin
        logic u, d;
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 204, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 204, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 204, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 204, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 208, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b1, 208, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 208, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 208, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 212, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 208, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 208, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 212, 1'b0};

        do_reset();
        check("reset y", int'(py[0]), 208);
        check("reset at_top", int'(at_t[0]), 0);
        check("reset at_bottom", int'(at_b[0]), 0);
        check("reset moving", int'(mov[0]), 0);
        check("reset y lo", int'(py[1]), 6);
        check("reset y hi", int'(py[2]), 414);

        for (int i = 0; i < 12; i++) begin
            cycle(tbl[i].u, tbl[i].d, tbl[i].t);
            check($sformatf("vec%0d y", i), int'(py[0]), tbl[i].y);
            check($sformatf("vec%0d moving", i), int'(mov[0]), int'(tbl[i].mv));
        end

        // long down hold: no motion for 8 ticks, then one step per tick
        do_reset();
        cycle(1'b0, 1'b1, 1'b0);
        check("hold dn press y", int'(py[0]), 212);
        for (int t = 1; t <= 20; t++) begin
            cycle(1'b0, 1'b1, 1'b1);
            check($sformatf("hold dn tick%0d y", t), int'(py[0]), (t <= 8) ? 212 : 212 + 4 * (t - 8));
            check($sformatf("hold dn tick%0d moving", t), int'(mov[0]), (t >= 8) ? 1 : 0);
            cycle(1'b0, 1'b1, 1'b0);
        end
        cycle(1'b1, 1'b0, 1'b0);
        check("reverse y", int'(py[0]), 256);
        check("reverse moving", int'(mov[0]), 0);
        for (int t = 1; t <= 9; t++) cycle(1'b1, 1'b0, 1'b1);
        check("rpt up y", int'(py[0]), 252);
        check("rpt up moving", int'(mov[0]), 1);

        // asynchronous reset mid-repeat with the button still held
        rst = 1'b1;
        #2;
        check("async rst y", int'(py[0]), 208);
        check("async rst moving", int'(mov[0]), 0);
        #1;
        rst = 1'b0;
        model_reset();
        cycle(1'b1, 1'b0, 1'b0);
        check("post rst press y", int'(py[0]), 204);

        // saturation at the top
        do_reset();
        cycle(1'b1, 1'b0, 1'b0);
        check("top press y", int'(py[1]), 2);
        check("top press at_top", int'(at_t[1]), 0);
        for (int t = 1; t <= 10; t++) begin
            cycle(1'b1, 1'b0, 1'b1);
            if (t >= 9) begin
                check($sformatf("top tick%0d y", t), int'(py[1]), 0);
                check($sformatf("top tick%0d at_top", t), int'(at_t[1]), 1);
            end
        end

        // saturation at the bottom
        do_reset();
        cycle(1'b0, 1'b1, 1'b0);
        check("bottom press y", int'(py[2]), 416);
        check("bottom at_bottom", int'(at_b[2]), 1);
        check("bottom main y", int'(py[0]), 212);

`ifdef PADDLE_ACCEL_EN
        do_reset();
        for (int t = 0; t < 70; t++) cycle(1'b1, 1'b0, 1'b1);
        check("accel reach top", int'(py[0]), 0);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        for (int t = 1; t <= 8 + 16; t++) cycle(1'b0, 1'b1, 1'b1);
        check("accel 16 steps y", int'(py[0]), 68);
        cycle(1'b0, 1'b1, 1'b1);
        check("accel step17 y", int'(py[0]), 76);
        cycle(1'b0, 1'b1, 1'b1);
        check("accel step18 y", int'(py[0]), 84);
`endif

        // random levels held for a while, frequent ticks
        do_reset();
        u = 1'b0;
        d = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(7) == 0) u = 1'($urandom_range(1));
            if ($urandom_range(7) == 0) d = 1'($urandom_range(1));
            cycle(u, d, ($urandom_range(3) == 0) ? 1'b1 : 1'b0);
            check_model();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
